// File: rtl/icache_plru_replacer.sv
// Tree pseudo-LRU victim selector for the 4-way I-Cache.
// Holds one 3-bit PLRU record {b2,b1,b0} per set. It picks the way to replace
// on a fill and marks the touched way most-recent on every completed access.
module icache_plru_replacer #(
  parameter int INDEX_WIDTH = 4,
  parameter int NUM_WAYS    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] index_i,
  input  logic [3:0]             valid_i,
  input  logic                   full_i,
  input  logic                   hit_i,
  input  logic [1:0]             hit_way_i,
  input  logic                   access_done_i,
  input  logic                   fill_i,
  input  logic                   flush_i,
  output logic [1:0]             evicted_way_o,
  output logic [2:0]             plru_bits_o,
  output logic                   update_err_o
);

  localparam int NUM_SETS = 1 << INDEX_WIDTH;
  localparam int WAY_W    = $clog2(NUM_WAYS);

  // Tree walk: b0 picks the half, then b1 (ways 0/1) or b2 (ways 2/3) picks the way.
  function automatic logic [1:0] plru_victim(input logic [2:0] bits);
    logic [1:0] way;
    if (bits[0] == 1'b0) begin
      way = bits[1] ? 2'd1 : 2'd0;
    end else begin
      way = bits[2] ? 2'd3 : 2'd2;
    end
    return way;
  endfunction

  // Point the tree away from the touched way, leaving the other subtree alone.
  function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
    logic [2:0] nxt;
    nxt = bits;
    case (way)
      2'd0:    begin nxt[0] = 1'b1; nxt[1] = 1'b1; end
      2'd1:    begin nxt[0] = 1'b1; nxt[1] = 1'b0; end
      2'd2:    begin nxt[0] = 1'b0; nxt[2] = 1'b1; end
      2'd3:    begin nxt[0] = 1'b0; nxt[2] = 1'b0; end
      default: nxt = bits;
    endcase
    return nxt;
  endfunction

  logic [2:0]       plru_q [NUM_SETS];
  logic [2:0]       plru_d [NUM_SETS];
  logic             update_err_q;
  logic             update_err_d;
  logic [2:0]       cur_bits_s;
  logic [1:0]       victim_s;
  logic [1:0]       target_way_s;
  logic             valid_update_s;
  logic             invalid_update_s;
  logic [WAY_W-1:0] hit_way_s;

  assign hit_way_s = hit_way_i[WAY_W-1:0];

  // Victim choice: first empty way while the set has room, tree walk otherwise.
  // valid=1111 with full=0 is inconsistent; the tree walk is the safe answer.
  always_comb begin
    cur_bits_s = plru_q[index_i];
    victim_s   = plru_victim(cur_bits_s);
    if (!full_i && (valid_i != 4'b1111)) begin
      if (!valid_i[0]) begin
        victim_s = 2'd0;
      end else if (!valid_i[1]) begin
        victim_s = 2'd1;
      end else if (!valid_i[2]) begin
        victim_s = 2'd2;
      end else begin
        victim_s = 2'd3;
      end
    end else begin
      victim_s = plru_victim(cur_bits_s);
    end
  end

  assign evicted_way_o = victim_s;
  assign plru_bits_o   = cur_bits_s;
  assign update_err_o  = update_err_q;

  // Next-state of the record array: flush clears all, a legal access touches one set.
  always_comb begin
    invalid_update_s = access_done_i && !fill_i && !hit_i;
    valid_update_s   = access_done_i && (fill_i || hit_i);
    target_way_s     = fill_i ? victim_s : hit_way_s;
    for (int s = 0; s < NUM_SETS; s++) begin
      plru_d[s] = plru_q[s];
    end
    if (flush_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_d[s] = 3'b000;
      end
    end else if (valid_update_s) begin
      plru_d[index_i] = plru_touch(cur_bits_s, target_way_s);
    end else begin
      plru_d[index_i] = plru_q[index_i];
    end
    // A hit-less, fill-less completion is an upstream protocol violation; it is
    // recorded even when a flush drops the access itself.
    update_err_d = update_err_q | invalid_update_s;
  end

  // Record array and sticky error flag; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_q[s] <= 3'b000;
      end
      update_err_q <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_q[s] <= plru_d[s];
      end
      update_err_q <= update_err_d;
    end
  end

endmodule

// File: tb/tb_icache_plru_replacer.sv
// Directed bench for icache_plru_replacer with hand-computed expectations.
module tb_icache_plru_replacer;

  logic       clk;
  logic       rst;
  logic [3:0] index_i;
  logic [3:0] valid_i;
  logic       full_i;
  logic       hit_i;
  logic [1:0] hit_way_i;
  logic       access_done_i;
  logic       fill_i;
  logic       flush_i;
  logic [1:0] evicted_way_o;
  logic [2:0] plru_bits_o;
  logic       update_err_o;

  int n_cmp;
  int n_bad;

  icache_plru_replacer #(.INDEX_WIDTH(4), .NUM_WAYS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .index_i       (index_i),
    .valid_i       (valid_i),
    .full_i        (full_i),
    .hit_i         (hit_i),
    .hit_way_i     (hit_way_i),
    .access_done_i (access_done_i),
    .fill_i        (fill_i),
    .flush_i       (flush_i),
    .evicted_way_o (evicted_way_o),
    .plru_bits_o   (plru_bits_o),
    .update_err_o  (update_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] fill_ev [4];
  logic [2:0] fill_pl [4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    fill_ev[0] = 2'd0; fill_ev[1] = 2'd2; fill_ev[2] = 2'd1; fill_ev[3] = 2'd3;
    fill_pl[0] = 3'b011; fill_pl[1] = 3'b110; fill_pl[2] = 3'b101; fill_pl[3] = 3'b000;

    rst = 1'b1; index_i = 4'd0; valid_i = 4'b0000; full_i = 1'b0; hit_i = 1'b0;
    hit_way_i = 2'd0; access_done_i = 1'b0; fill_i = 1'b0; flush_i = 1'b0;
    #12;
    chk("rst_err", update_err_o, 1'b0);
    rst = 1'b0;

    // Reset state on index 5 with a full set.
    index_i = 4'd5; valid_i = 4'b1111; full_i = 1'b1; #1;
    chk("rst_ev", evicted_way_o, 2'd0);
    chk("rst_plru", plru_bits_o, 3'b000);

    // Non-full set: lowest invalid way.
    index_i = 4'd3; valid_i = 4'b1011; full_i = 1'b0; #1;
    chk("free_way2", evicted_way_o, 2'd2);
    valid_i = 4'b0000; #1;
    chk("free_way0", evicted_way_o, 2'd0);
    valid_i = 4'b0111; #1;
    chk("free_way3", evicted_way_o, 2'd3);

    // Four fills on a full set cycle through 0,2,1,3.
    tick();
    index_i = 4'd7; valid_i = 4'b1111; full_i = 1'b1; access_done_i = 1'b1; fill_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fill_ev%0d", i), evicted_way_o, fill_ev[i]);
      tick();
      chk($sformatf("fill_plru%0d", i), plru_bits_o, fill_pl[i]);
    end
    // Fifth fill leaves set 7 at 011 so later isolation checks see a nonzero record.
    tick();
    access_done_i = 1'b0; fill_i = 1'b0; #1;
    chk("fill5_plru", plru_bits_o, 3'b011);

    // Hits on set 2: way1, way2 (b1 kept), way0 (b2 kept).
    index_i = 4'd2; hit_i = 1'b1; hit_way_i = 2'd1; access_done_i = 1'b1;
    tick();
    access_done_i = 1'b0; #1;
    chk("hit1_plru", plru_bits_o, 3'b001);
    chk("hit1_ev", evicted_way_o, 2'd2);
    hit_way_i = 2'd2; access_done_i = 1'b1;
    tick();
    access_done_i = 1'b0; #1;
    chk("hit2_plru", plru_bits_o, 3'b100);
    hit_way_i = 2'd0; access_done_i = 1'b1;
    tick();
    access_done_i = 1'b0; #1;
    chk("hit0_plru", plru_bits_o, 3'b111);
    chk("hit0_ev", evicted_way_o, 2'd3);
    index_i = 4'd7; #1;
    chk("iso_set7", plru_bits_o, 3'b011);
    index_i = 4'd3; #1;
    chk("iso_set3", plru_bits_o, 3'b000);

    // Fill sets 9 and 10, then flush together with an access.
    hit_i = 1'b0; index_i = 4'd9; fill_i = 1'b1; access_done_i = 1'b1;
    tick();
    index_i = 4'd10;
    tick();
    access_done_i = 1'b0; #1;
    chk("pre_fl_set10", plru_bits_o, 3'b011);
    index_i = 4'd9; #1;
    chk("pre_fl_set9", plru_bits_o, 3'b011);
    access_done_i = 1'b1; flush_i = 1'b1;
    tick();
    access_done_i = 1'b0; flush_i = 1'b0; fill_i = 1'b0;
    for (int s = 0; s < 16; s++) begin
      index_i = s[3:0]; #1;
      chk($sformatf("flush_set%0d", s), plru_bits_o, 3'b000);
    end
    chk("flush_err", update_err_o, 1'b0);

    // Invalid update: record holds, sticky error set.
    index_i = 4'd4; hit_i = 1'b1; hit_way_i = 2'd1; access_done_i = 1'b1;
    tick();
    hit_i = 1'b0; hit_way_i = 2'd2; #1;
    chk("bad_pre_plru", plru_bits_o, 3'b001);
    tick();
    access_done_i = 1'b0; #1;
    chk("bad_plru", plru_bits_o, 3'b001);
    chk("bad_err", update_err_o, 1'b1);
    index_i = 4'd2; hit_i = 1'b1; hit_way_i = 2'd3; access_done_i = 1'b1;
    tick();
    access_done_i = 1'b0; hit_i = 1'b0; #1;
    chk("err_sticky", update_err_o, 1'b1);
    chk("good_plru", plru_bits_o, 3'b000);
    index_i = 4'd4; #1;
    chk("good_iso4", plru_bits_o, 3'b001);

    // Async reset mid-cycle clears everything before the next edge.
    @(negedge clk);
    rst = 1'b1; #1;
    chk("arst_err", update_err_o, 1'b0);
    chk("arst_set4", plru_bits_o, 3'b000);
    rst = 1'b0;
    index_i = 4'd7; #1;
    chk("arst_set7", plru_bits_o, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
